btn_debounce: RTL

Button input conditioner for the board push-buttons. It synchronises a raw, bouncing button input to `clk` and debounces it with a four-state FSM. It emits a clean level, single-cycle press/release/long-press pulses, and a press-toggled direction flag. It sits between the board button pin and the LED pattern logic, which consumes `dir` and `press_pulse` instead of sampling the button directly.

---
 rtl/btn_pkg.sv | 15 +
 rtl/sync_2ff.sv | 21 ++
 rtl/btn_debounce.sv | 125 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the board push-button conditioners.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Defaults sized for the 100 MHz board clock: 10 ms debounce, 1 s long press.
    localparam int BTN_DEBOUNCE_DEF = 1_000_000;
    localparam int BTN_LONG_DEF     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous board inputs, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level, press/release/long pulses and dir.
// Long-press detection (hold_cnt, long_pulse) is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_DEF,
    parameter int LONG_CYC     = BTN_LONG_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic dir
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_param_check
        $error("btn_debounce: DEBOUNCE_CYC and LONG_CYC must be >= 1");
    end

    btn_state_t      state;
    logic [DB_W-1:0] db_cnt;
    logic            sync_q;
    logic            press_acc;
    logic            release_acc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_q)
    );

    assign press_acc   = (state == PRESS_WAIT)   &&  sync_q && (db_cnt == DB_LAST);
    assign release_acc = (state == RELEASE_WAIT) && !sync_q && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            dir           <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_q) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q) begin
                        state <= IDLE;
                    end else if (press_acc) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        dir         <= ~dir;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_q) begin
                        state <= PRESSED;
                    end else if (release_acc) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              holding;

    // The hold runs from press acceptance through release bounces; the edge that
    // accepts the release ends the press, so no long pulse can share its cycle.
    assign holding = ((state == PRESSED) || (state == RELEASE_WAIT)) && !release_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_acc) begin
                hold_cnt <= '0;
            end else if (holding && (hold_cnt != HOLD_LAST)) begin
                hold_cnt   <= hold_cnt + HOLD_ONE;
                long_pulse <= (hold_cnt == HOLD_LAST - HOLD_ONE);
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule
